// File: rtl/uart_cmd_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_rx
// Brief    : 8N1 UART receiver with a command filter and hold/gap presenter
//            that drives the stats block command bus. Letters are folded to
//            lowercase. Only {e,p,d,b,s,w} are passed. Each command is held
//            for a fixed window and then followed by a mandatory 0x00 gap.
//            A single pending slot absorbs back-to-back keystrokes.
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_rx #(
    parameter int CLKS_PER_BIT = 2812,
    parameter int HOLD_CYCLES  = 27000,
    parameter int GAP_CYCLES   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] cmd,
    output logic       cmd_valid,
    output logic [7:0] rx_byte,
    output logic       rx_strobe,
    output logic       framing_err,
    output logic       overrun,
    output logic       busy
);

    // Receive FSM encoding
    localparam logic [2:0] R_IDLE  = 3'd0;
    localparam logic [2:0] R_START = 3'd1;
    localparam logic [2:0] R_DATA  = 3'd2;
    localparam logic [2:0] R_STOP  = 3'd3;
    localparam logic [2:0] R_WAIT  = 3'd4;

    // Output FSM encoding
    localparam logic [1:0] O_IDLE = 2'd0;
    localparam logic [1:0] O_HOLD = 2'd1;
    localparam logic [1:0] O_GAP  = 2'd2;

    localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    localparam int                OMAX      = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int                OCNT_W    = $clog2(OMAX + 1);
    localparam logic [OCNT_W-1:0] HOLD_LAST = OCNT_W'(HOLD_CYCLES - 1);
    localparam logic [OCNT_W-1:0] GAP_LAST  = OCNT_W'(GAP_CYCLES - 1);

    // Synchroniser chain plus one extra stage for falling-edge detection
    logic rx_meta_q, rx_meta_d;
    logic rx_s_q, rx_s_d;
    logic rx_prev_q, rx_prev_d;

    // Receive datapath
    logic [2:0]       rstate_q, rstate_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_byte_q, rx_byte_d;
    logic             rx_strobe_q, rx_strobe_d;
    logic             framing_err_q, framing_err_d;

    // Output presenter
    logic [1:0]        ostate_q, ostate_d;
    logic [OCNT_W-1:0] ocnt_q, ocnt_d;
    logic [7:0]        cmd_q, cmd_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [7:0]        pend_q, pend_d;
    logic              pend_valid_q, pend_valid_d;
    logic              overrun_q, overrun_d;

    // Event strobes from the FSM next-state logic
    logic       w_stop_good;
    logic       w_stop_bad;
    logic       w_hold_done;
    logic       w_gap_done;
    logic [7:0] w_lower;
    logic       w_is_cmd;
    logic       w_accept;

    // Synchroniser next values: a plain shift chain
    always_comb begin
        rx_meta_d = rx;
        rx_s_d    = rx_meta_q;
        rx_prev_d = rx_s_q;
    end

    // State register for every flop; reset parks both FSMs and idles the line high
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q     <= 1'b1;
            rx_s_q        <= 1'b1;
            rx_prev_q     <= 1'b1;
            rstate_q      <= R_IDLE;
            clk_cnt_q     <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            rx_byte_q     <= '0;
            rx_strobe_q   <= 1'b0;
            framing_err_q <= 1'b0;
            ostate_q      <= O_IDLE;
            ocnt_q        <= '0;
            cmd_q         <= '0;
            cmd_valid_q   <= 1'b0;
            pend_q        <= '0;
            pend_valid_q  <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            rx_meta_q     <= rx_meta_d;
            rx_s_q        <= rx_s_d;
            rx_prev_q     <= rx_prev_d;
            rstate_q      <= rstate_d;
            clk_cnt_q     <= clk_cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            rx_byte_q     <= rx_byte_d;
            rx_strobe_q   <= rx_strobe_d;
            framing_err_q <= framing_err_d;
            ostate_q      <= ostate_d;
            ocnt_q        <= ocnt_d;
            cmd_q         <= cmd_d;
            cmd_valid_q   <= cmd_valid_d;
            pend_q        <= pend_d;
            pend_valid_q  <= pend_valid_d;
            overrun_q     <= overrun_d;
        end
    end

    // Receive FSM next state: mid-bit sampling timed from the start edge
    always_comb begin
        rstate_d    = rstate_q;
        clk_cnt_d   = clk_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        w_stop_good = 1'b0;
        w_stop_bad  = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                if (rx_prev_q && !rx_s_q) begin
                    rstate_d  = R_START;
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                end
            end
            R_START: begin
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d = '0;
                    // A high line at mid start bit was only a glitch
                    rstate_d  = rx_s_q ? R_IDLE : R_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            R_DATA: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        rstate_d = R_STOP;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            R_STOP: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    if (rx_s_q) begin
                        w_stop_good = 1'b1;
                        rstate_d    = R_IDLE;
                    end else begin
                        w_stop_bad = 1'b1;
                        rstate_d   = R_WAIT;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            R_WAIT: begin
                // Hold off until the line idles so a break cannot frame bytes
                if (rx_s_q) begin
                    rstate_d = R_IDLE;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    // Receive FSM outputs: raw byte capture and one-cycle status pulses
    always_comb begin
        rx_byte_d     = w_stop_good ? shift_q : rx_byte_q;
        rx_strobe_d   = w_stop_good;
        framing_err_d = w_stop_bad;
    end

    // Command filter: fold A-Z to lowercase, then match the command set
    always_comb begin
        w_lower = shift_q;
        if ((shift_q >= 8'h41) && (shift_q <= 8'h5A)) begin
            w_lower = shift_q + 8'h20;
        end
        case (w_lower)
            8'h65, 8'h70, 8'h64, 8'h62, 8'h73, 8'h77: w_is_cmd = 1'b1;
            default:                                  w_is_cmd = 1'b0;
        endcase
        w_accept = w_stop_good && w_is_cmd;
    end

    // Output FSM next state: hold window followed by a fixed gap
    always_comb begin
        ostate_d    = ostate_q;
        ocnt_d      = ocnt_q;
        w_hold_done = 1'b0;
        w_gap_done  = 1'b0;
        case (ostate_q)
            O_IDLE: begin
                if (w_accept) begin
                    ostate_d = O_HOLD;
                    ocnt_d   = '0;
                end
            end
            O_HOLD: begin
                if (ocnt_q == HOLD_LAST) begin
                    w_hold_done = 1'b1;
                    ostate_d    = O_GAP;
                    ocnt_d      = '0;
                end else begin
                    ocnt_d = ocnt_q + OCNT_W'(1);
                end
            end
            O_GAP: begin
                if (ocnt_q == GAP_LAST) begin
                    w_gap_done = 1'b1;
                    ocnt_d     = '0;
                    // A byte arriving on the final gap edge starts the next hold directly
                    ostate_d   = (pend_valid_q || w_accept) ? O_HOLD : O_IDLE;
                end else begin
                    ocnt_d = ocnt_q + OCNT_W'(1);
                end
            end
            default: ostate_d = O_IDLE;
        endcase
    end

    // Output FSM outputs: cmd bus, pending slot and overrun pulse
    always_comb begin
        cmd_d        = cmd_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        overrun_d    = 1'b0;
        case (ostate_q)
            O_IDLE: begin
                if (w_accept) begin
                    cmd_d = w_lower;
                end
            end
            O_HOLD: begin
                if (w_hold_done) begin
                    cmd_d = 8'h00;
                end
                if (w_accept) begin
                    if (pend_valid_q) begin
                        overrun_d = 1'b1;
                    end else begin
                        pend_d       = w_lower;
                        pend_valid_d = 1'b1;
                    end
                end
            end
            O_GAP: begin
                if (w_gap_done) begin
                    if (pend_valid_q) begin
                        // Slot drains into cmd this edge, so a new byte may refill it
                        cmd_d = pend_q;
                        if (w_accept) begin
                            pend_d = w_lower;
                        end else begin
                            pend_valid_d = 1'b0;
                        end
                    end else if (w_accept) begin
                        cmd_d = w_lower;
                    end
                end else if (w_accept) begin
                    if (pend_valid_q) begin
                        overrun_d = 1'b1;
                    end else begin
                        pend_d       = w_lower;
                        pend_valid_d = 1'b1;
                    end
                end
            end
            default: cmd_d = 8'h00;
        endcase
        cmd_valid_d = (cmd_d != 8'h00);
    end

    assign cmd         = cmd_q;
    assign cmd_valid   = cmd_valid_q;
    assign rx_byte     = rx_byte_q;
    assign rx_strobe   = rx_strobe_q;
    assign framing_err = framing_err_q;
    assign overrun     = overrun_q;
    assign busy        = (rstate_q != R_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cmd_rx
// Brief    : Directed bench for uart_cmd_rx. Instance A uses the short hold
//            window. Instance B shares the serial line and uses a long hold,
//            so that back-to-back frames land inside one hold window.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_rx;

    localparam int CPB    = 8;
    localparam int HOLD   = 20;
    localparam int GAP    = 4;
    localparam int HOLD_B = 200;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] cmd_a, rx_byte_a, cmd_b, rx_byte_b;
    logic       cmd_valid_a, rx_strobe_a, ferr_a, ovr_a, busy_a;
    logic       cmd_valid_b, rx_strobe_b, ferr_b, ovr_b, busy_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_cmd_rx #(.CLKS_PER_BIT(CPB), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) u_dut_a (
        .clk(clk), .reset(reset), .rx(rx),
        .cmd(cmd_a), .cmd_valid(cmd_valid_a), .rx_byte(rx_byte_a), .rx_strobe(rx_strobe_a),
        .framing_err(ferr_a), .overrun(ovr_a), .busy(busy_a)
    );

    uart_cmd_rx #(.CLKS_PER_BIT(CPB), .HOLD_CYCLES(HOLD_B), .GAP_CYCLES(GAP)) u_dut_b (
        .clk(clk), .reset(reset), .rx(rx),
        .cmd(cmd_b), .cmd_valid(cmd_valid_b), .rx_byte(rx_byte_b), .rx_strobe(rx_strobe_b),
        .framing_err(ferr_b), .overrun(ovr_b), .busy(busy_b)
    );

    // Run-length logs of cmd: each entry is (value << 16) | length in clocks
    int         log_a[$];
    int         log_b[$];
    logic [7:0] cur_a = 8'h00, cur_b = 8'h00;
    int         len_a = 0, len_b = 0;
    int         n_strobe = 0, n_ferr = 0, n_ovr_a = 0, n_ovr_b = 0, n_cv_bad = 0;
    logic [7:0] last_byte = 8'h00;

    // Observe outputs on the falling edge, clear of the active edge
    always @(negedge clk) begin
        if (cmd_a == cur_a) len_a++;
        else begin
            if (len_a > 0) log_a.push_back((int'(cur_a) << 16) | len_a);
            cur_a = cmd_a;
            len_a = 1;
        end
        if (cmd_b == cur_b) len_b++;
        else begin
            if (len_b > 0) log_b.push_back((int'(cur_b) << 16) | len_b);
            cur_b = cmd_b;
            len_b = 1;
        end
        if (rx_strobe_a) begin
            n_strobe++;
            last_byte = rx_byte_a;
        end
        if (ferr_a) n_ferr++;
        if (ovr_a)  n_ovr_a++;
        if (ovr_b)  n_ovr_b++;
        if ((cmd_valid_a != (cmd_a != 8'h00)) || (cmd_valid_b != (cmd_b != 8'h00))) n_cv_bad++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic log_clear();
        @(negedge clk);
        #1;
        log_a.delete();
        log_b.delete();
        cur_a    = cmd_a;
        cur_b    = cmd_b;
        len_a    = 0;
        len_b    = 0;
        n_strobe = 0;
        n_ferr   = 0;
        n_ovr_a  = 0;
        n_ovr_b  = 0;
    endtask

    task automatic log_flush();
        @(negedge clk);
        #1;
        if (len_a > 0) log_a.push_back((int'(cur_a) << 16) | len_a);
        if (len_b > 0) log_b.push_back((int'(cur_b) << 16) | len_b);
        len_a = 0;
        len_b = 0;
    endtask

    function automatic int nz_count(input int q[$]);
        int n = 0;
        foreach (q[i]) if ((q[i] >> 16) != 0) n++;
        return n;
    endfunction

    // what: 0 = value of k-th nonzero run, 1 = its length, 2 = length of the run after it
    function automatic int nz_field(input int q[$], input int k, input int what);
        int n = 0;
        for (int i = 0; i < q.size(); i++) begin
            if ((q[i] >> 16) != 0) begin
                if (n == k) begin
                    if (what == 0) return q[i] >> 16;
                    if (what == 1) return q[i] & 'hFFFF;
                    if (i + 1 < q.size()) return q[i+1] & 'hFFFF;
                    return -1;
                end
                n++;
            end
        end
        return -1;
    endfunction

    // Drive one 8N1 frame; a nonzero cut releases the line after that many clocks
    task automatic send_frame(input logic [7:0] d, input logic stop, input int cut);
        logic [9:0] bits;
        int         n;
        bits = {stop, d, 1'b0};
        n    = 0;
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < CPB; j++) begin
                if ((cut > 0) && (n == cut)) begin
                    rx = 1'b1;
                    return;
                end
                @(negedge clk);
                rx = bits[i];
                n++;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic int outs_a();
        return int'({cmd_a, cmd_valid_a, rx_byte_a, rx_strobe_a, ferr_a, ovr_a, busy_a});
    endfunction

    function automatic int outs_b();
        return int'({cmd_b, cmd_valid_b, rx_byte_b, rx_strobe_b, ferr_b, ovr_b, busy_b});
    endfunction

    initial begin
        int  gap_after;
        bit  seen_busy;
        bit  busy_low;

        // Reset state
        idle(3);
        chk("reset_outs_a", outs_a(), 0);
        chk("reset_outs_b", outs_b(), 0);
        reset = 1'b0;
        idle(5);

        // Single 'e'
        log_clear();
        send_frame(8'h65, 1'b1, 0);
        idle(260);
        log_flush();
        chk("e_strobes", n_strobe, 1);
        chk("e_rx_byte", int'(last_byte), 'h65);
        chk("e_ferr", n_ferr, 0);
        chk("e_ovr", n_ovr_a, 0);
        chk("e_nz_runs", nz_count(log_a), 1);
        chk("e_cmd", nz_field(log_a, 0, 0), 'h65);
        chk("e_hold_len", nz_field(log_a, 0, 1), HOLD);
        gap_after = nz_field(log_a, 0, 2);
        chk("e_gap_min", int'(gap_after >= GAP), 1);

        // Uppercase 'P' folds to 'p'
        log_clear();
        send_frame(8'h50, 1'b1, 0);
        idle(260);
        log_flush();
        chk("P_rx_byte", int'(last_byte), 'h50);
        chk("P_cmd", nz_field(log_a, 0, 0), 'h70);
        chk("P_hold_len", nz_field(log_a, 0, 1), HOLD);

        // 'x' is not a command: strobe only
        log_clear();
        send_frame(8'h78, 1'b1, 0);
        idle(60);
        log_flush();
        chk("x_strobes", n_strobe, 1);
        chk("x_rx_byte", int'(last_byte), 'h78);
        chk("x_nz_runs", nz_count(log_a), 0);

        // Back-to-back e, e, s
        log_clear();
        send_frame(8'h65, 1'b1, 0);
        send_frame(8'h65, 1'b1, 0);
        send_frame(8'h73, 1'b1, 0);
        idle(500);
        log_flush();
        chk("b2b_a_runs", nz_count(log_a), 3);
        chk("b2b_a_third", nz_field(log_a, 2, 0), 'h73);
        chk("b2b_a_ovr", n_ovr_a, 0);
        chk("b2b_b_runs", nz_count(log_b), 2);
        chk("b2b_b_cmd0", nz_field(log_b, 0, 0), 'h65);
        chk("b2b_b_len0", nz_field(log_b, 0, 1), HOLD_B);
        chk("b2b_b_gap0", nz_field(log_b, 0, 2), GAP);
        chk("b2b_b_cmd1", nz_field(log_b, 1, 0), 'h65);
        chk("b2b_b_len1", nz_field(log_b, 1, 1), HOLD_B);
        gap_after = nz_field(log_b, 1, 2);
        chk("b2b_b_gap1_min", int'(gap_after >= GAP), 1);
        chk("b2b_b_ovr", n_ovr_b, 1);

        // Framing error followed by a long low line
        log_clear();
        send_frame(8'h65, 1'b0, 0);
        idle(30);
        rx = 1'b1;
        idle(40);
        log_flush();
        chk("ferr_count", n_ferr, 1);
        chk("ferr_strobes", n_strobe, 0);
        chk("ferr_nz_a", nz_count(log_a), 0);
        chk("ferr_nz_b", nz_count(log_b), 0);
        log_clear();
        send_frame(8'h77, 1'b1, 0);
        idle(260);
        log_flush();
        chk("w_cmd", nz_field(log_a, 0, 0), 'h77);
        chk("w_hold_len", nz_field(log_a, 0, 1), HOLD);

        // Two-clock glitch while idle
        log_clear();
        @(negedge clk);
        rx = 1'b0;
        idle(2);
        rx = 1'b1;
        seen_busy = 1'b0;
        busy_low  = 1'b0;
        for (int k = 0; k < CPB / 2 + 3; k++) begin
            @(negedge clk);
            if (busy_a) seen_busy = 1'b1;
            else if (seen_busy) begin
                busy_low = 1'b1;
                break;
            end
        end
        chk("glitch_busy_seen", int'(seen_busy), 1);
        chk("glitch_busy_clear", int'(busy_low), 1);
        idle(20);
        chk("glitch_strobes", n_strobe, 0);
        chk("glitch_ferr", n_ferr, 0);

        // Reset in the middle of a data bit
        log_clear();
        send_frame(8'h65, 1'b0, 30);
        chk("rst_data_busy_before", int'(busy_a), 1);
        pulse_reset();
        chk("rst_data_outs_a", outs_a(), 0);
        chk("rst_data_outs_b", outs_b(), 0);
        log_clear();
        idle(120);
        log_flush();
        chk("rst_data_strobes", n_strobe, 0);
        chk("rst_data_nz", nz_count(log_a), 0);

        // Reset in the middle of a hold, with B's pending slot full
        send_frame(8'h65, 1'b1, 0);
        send_frame(8'h65, 1'b1, 0);
        idle(8);
        chk("rst_hold_cmd_a_before", int'(cmd_a), 'h65);
        chk("rst_hold_cmd_b_before", int'(cmd_b), 'h65);
        pulse_reset();
        chk("rst_hold_outs_a", outs_a(), 0);
        chk("rst_hold_outs_b", outs_b(), 0);
        log_clear();
        idle(300);
        log_flush();
        chk("rst_hold_nz_a", nz_count(log_a), 0);
        chk("rst_hold_nz_b", nz_count(log_b), 0);

        // Fresh 'd' after reset
        log_clear();
        send_frame(8'h64, 1'b1, 0);
        idle(260);
        log_flush();
        chk("d_cmd_a", nz_field(log_a, 0, 0), 'h64);
        chk("d_len_a", nz_field(log_a, 0, 1), HOLD);
        chk("d_cmd_b", nz_field(log_b, 0, 0), 'h64);
        chk("d_len_b", nz_field(log_b, 0, 1), HOLD_B);

        chk("cmd_valid_tracks_cmd", n_cv_bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
